// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch front end.
//   - redirect-kind encodings driven by the execute stage
//   - opcode match constants used by the static branch predecoder
//   - instruction size in bytes
//   - predict_taken(): backward-taken / forward-not-taken predecode helper
package fetch_pkg;

   typedef enum logic [1:0] {
      REDIR_NONE = 2'b00,
      REDIR_REL  = 2'b01,
      REDIR_REG  = 2'b10
   } redir_kind_e;

   localparam logic [5:0] OP_B     = 6'b000101;
   localparam logic [7:0] OP_CBZ   = 8'b10110100;
   localparam logic [7:0] OP_CBNZ  = 8'b10110101;
   localparam logic [7:0] OP_BCOND = 8'b01010100;

   localparam int INSTR_BYTES = 4;

   // Unconditional B is always taken; conditional branches are taken only
   // when their imm19 is negative (a backward branch, typically a loop).
   function automatic logic predict_taken(input logic [31:0] instr);
      if (instr[31:26] == OP_B) begin
         return 1'b1;
      end
      if ((instr[31:24] == OP_CBZ) || (instr[31:24] == OP_CBNZ) ||
          (instr[31:24] == OP_BCOND)) begin
         return instr[23];
      end
      return 1'b0;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer holding fetched {instr, pc, pred} entries.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wr_data     enqueue at the write pointer
//   pop               dequeue the head (ignored while empty)
//   flush             empty the queue; overrides push/pop
//   rd_data           head entry (raw storage, not gated by occupancy)
//   count             occupancy, 0..DEPTH
module fetch_fifo #(
   parameter int DEPTH   = 4,
   parameter int ENTRY_W = 97
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [ENTRY_W-1:0]         wr_data,
   output logic [ENTRY_W-1:0]         rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0][ENTRY_W-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]              count_q, count_d;
   logic                          pop_eff, push_eff;

   assign pop_eff  = pop && (count_q != '0);
   assign push_eff = push && ((count_q < CNT_W'(DEPTH)) || pop_eff);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_eff) begin
            mem_d[wr_ptr_q] = wr_data;
            // DEPTH is a power of two, so the pointer wraps by overflow.
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage with PC ownership and a DEPTH-entry instruction queue to decode.
// Optional feature macro: FETCH_STATIC_PREDICT_EN (static B / backward-branch
// prediction at fetch time; when undefined, fetch is purely sequential).
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   imem_addr / imem_instr     instruction memory (combinational read at PC)
//   redir_*, condAddr19/26     execute-stage redirect (flushes the queue)
//   fq_valid/fq_ready          head handshake to decode
//   fq_instr/fq_pc/fq_pred_taken  head contents, zero while fq_valid = 0
//   fq_count                   occupancy
// Requires ADDR_W >= 28 so the shifted imm26 fits.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int               ADDR_W   = 64,
   parameter int               INSTR_W  = 32,
   parameter int               DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic [INSTR_W-1:0]         imem_instr,
   input  logic [1:0]                 redir_kind,
   input  logic                       redir_uncond,
   input  logic [ADDR_W-1:0]          redir_base_pc,
   input  logic [18:0]                condAddr19,
   input  logic [25:0]                condAddr26,
   input  logic [ADDR_W-1:0]          redir_reg_pc,
   output logic                       fq_valid,
   input  logic                       fq_ready,
   output logic [INSTR_W-1:0]         fq_instr,
   output logic [ADDR_W-1:0]          fq_pc,
   output logic                       fq_pred_taken,
   output logic [$clog2(DEPTH+1)-1:0] fq_count
);

   localparam int CNT_W   = $clog2(DEPTH+1);
   localparam int ENTRY_W = INSTR_W + ADDR_W + 1;

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  off19, off26, rel_target, pred_target;
   logic               redir_rel, redir_reg, redirect;
   logic               pop, push, pred;
   logic [CNT_W-1:0]   count;
   logic [ENTRY_W-1:0] head;

   // Word offsets, sign-extended and scaled to bytes.
   assign off19 = {{(ADDR_W-21){condAddr19[18]}}, condAddr19, 2'b00};
   assign off26 = {{(ADDR_W-28){condAddr26[25]}}, condAddr26, 2'b00};

   // Kind 11 is reserved and behaves like no redirect.
   assign redir_rel  = (redir_kind == REDIR_REL);
   assign redir_reg  = (redir_kind == REDIR_REG);
   assign redirect   = redir_rel || redir_reg;
   assign rel_target = redir_base_pc + (redir_uncond ? off26 : off19);

   assign fq_valid = (count != '0);
   assign pop      = fq_valid && fq_ready;
   assign push     = !redirect && ((count < CNT_W'(DEPTH)) || pop);

`ifdef FETCH_STATIC_PREDICT_EN
   logic [ADDR_W-1:0] pre_off19, pre_off26;
   assign pre_off19   = {{(ADDR_W-21){imem_instr[23]}}, imem_instr[23:5], 2'b00};
   assign pre_off26   = {{(ADDR_W-28){imem_instr[25]}}, imem_instr[25:0], 2'b00};
   assign pred        = predict_taken(imem_instr[31:0]);
   assign pred_target = pc_q + ((imem_instr[31:26] == OP_B) ? pre_off26 : pre_off19);
`else
   assign pred        = 1'b0;
   assign pred_target = pc_q + ADDR_W'(INSTR_BYTES);
`endif

   always_comb begin
      pc_d = pc_q;
      if (redir_rel) begin
         pc_d = rel_target;
      end else if (redir_reg) begin
         pc_d = redir_reg_pc;
      end else if (push) begin
         pc_d = pred ? pred_target : pc_q + ADDR_W'(INSTR_BYTES);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push    (push),
      .pop     (pop && !redirect),
      .flush   (redirect),
      .wr_data ({imem_instr, pc_q, pred}),
      .rd_data (head),
      .count   (count)
   );

   assign imem_addr = pc_q;
   assign fq_count  = count;

   // Stale storage behind the head is masked so the outputs read zero when empty.
   assign fq_instr      = fq_valid ? head[ENTRY_W-1 -: INSTR_W] : '0;
   assign fq_pc         = fq_valid ? head[ADDR_W:1]             : '0;
   assign fq_pred_taken = fq_valid ? head[0]                    : 1'b0;

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

   logic        clk;
   logic        reset;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic [1:0]  redir_kind;
   logic        redir_uncond;
   logic [63:0] redir_base_pc;
   logic [18:0] condAddr19;
   logic [25:0] condAddr26;
   logic [63:0] redir_reg_pc;
   logic        fq_valid;
   logic        fq_ready;
   logic [31:0] fq_instr;
   logic [63:0] fq_pc;
   logic        fq_pred_taken;
   logic [2:0]  fq_count;

   int n_vec = 0;
   int n_err = 0;
   logic [63:0] exp_q[$];

   fetch_queue_unit #(
      .ADDR_W   (64),
      .INSTR_W  (32),
      .DEPTH    (4),
      .RESET_PC (64'h0)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_addr     (imem_addr),
      .imem_instr    (imem_instr),
      .redir_kind    (redir_kind),
      .redir_uncond  (redir_uncond),
      .redir_base_pc (redir_base_pc),
      .condAddr19    (condAddr19),
      .condAddr26    (condAddr26),
      .redir_reg_pc  (redir_reg_pc),
      .fq_valid      (fq_valid),
      .fq_ready      (fq_ready),
      .fq_instr      (fq_instr),
      .fq_pc         (fq_pc),
      .fq_pred_taken (fq_pred_taken),
      .fq_count      (fq_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
`ifdef FETCH_STATIC_PREDICT_EN
      if (a == 64'h2000) return 32'h1400_0004;   // B +4 words
      if (a == 64'h2010) return 32'hB400_00A0;   // CBZ +5 words
      if (a == 64'h2014) return 32'hB4FF_FFA0;   // CBZ -3 words
`endif
      return {8'hD5, a[23:0]};
   endfunction

   assign imem_instr = mem_word(imem_addr);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_seq(input logic [63:0] start, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(start + 64'(4 * i));
   endtask

   // Head popped at the coming edge: compare against the next expected PC.
   always @(negedge clk) begin
      if (reset && fq_valid && fq_ready && !(redir_kind == 2'b01 || redir_kind == 2'b10)) begin
         if (exp_q.size() > 0) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("sb_pc", fq_pc, e);
            check("sb_instr", 64'(fq_instr), 64'(mem_word(e)));
         end else begin
            n_vec++;
            n_err++;
            $display("FAIL sb_unexpected: got pc %h expected no pop", fq_pc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; fq_ready = 1'b0; redir_kind = 2'b00; redir_uncond = 1'b0;
      redir_base_pc = '0; condAddr19 = '0; condAddr26 = '0; redir_reg_pc = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(fq_valid), 64'd0);
      check("rst_count", 64'(fq_count), 64'd0);
      check("rst_addr", imem_addr, 64'd0);
      check("rst_pc", fq_pc, 64'd0);
      check("rst_instr", 64'(fq_instr), 64'd0);

      // Stall: fill to DEPTH, PC holds at 16
      @(negedge clk) reset = 1'b1;
      expect_seq(64'h0, 5);
      for (int i = 1; i <= 6; i++) begin
         step();
         if (i == 1) begin
            check("a_first_head", fq_pc, 64'h0);
            check("a_first_count", 64'(fq_count), 64'd1);
         end
         if (i >= 4) begin
            check("a_full_count", 64'(fq_count), 64'd4);
            check("a_pc_hold", imem_addr, 64'h10);
         end
      end
      check("a_pred_off", 64'(fq_pred_taken), 64'd0);
      fq_ready = 1'b1;
      repeat (5) step();
      check("a_full_pop_count", 64'(fq_count), 64'd4);
      check("a_head_after", fq_pc, 64'h14);
      check("a_drain", 64'(exp_q.size()), 64'd0);

      // Register redirect with push and pop both active, then reserved kind
      redir_kind = 2'b10; redir_reg_pc = 64'h1000;
      step();
      redir_kind = 2'b11; redir_reg_pc = 64'h2000; redir_base_pc = 64'h500; condAddr19 = 19'd1;
      check("c_count", 64'(fq_count), 64'd0);
      check("c_valid", 64'(fq_valid), 64'd0);
      check("c_addr", imem_addr, 64'h1000);
      check("c_pc_zero", fq_pc, 64'h0);
      expect_seq(64'h1000, 1);
      step();
      check("c_head", fq_pc, 64'h1000);
      check("c_k3_addr", imem_addr, 64'h1004);
      step();
      check("c_k3_seq", imem_addr, 64'h1008);
      check("c_k3_count", 64'(fq_count), 64'd1);

      // Build up 3 entries, then PC-relative redirect via condAddr19
      redir_kind = 2'b00; fq_ready = 1'b0;
      repeat (2) step();
      check("b_count3", 64'(fq_count), 64'd3);
      redir_kind = 2'b01; redir_uncond = 1'b0; condAddr19 = 19'h7FFFE;
      condAddr26 = 26'd100; redir_base_pc = 64'h40; fq_ready = 1'b1;
      step();
      redir_kind = 2'b00;
      check("b_flush_count", 64'(fq_count), 64'd0);
      check("b_flush_valid", 64'(fq_valid), 64'd0);
      check("b_target", imem_addr, 64'h38);
      step();
      check("b_head", fq_pc, 64'h38);
      check("b_head_count", 64'(fq_count), 64'd1);

      // Unconditional relative redirect wrapping below zero; head 0x38 is flushed
      redir_kind = 2'b01; redir_uncond = 1'b1; condAddr26 = 26'h3FFFFFF;
      condAddr19 = 19'd7; redir_base_pc = 64'h0;
      step();
      redir_kind = 2'b00;
      check("w_count", 64'(fq_count), 64'd0);
      check("w_target", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      expect_seq(64'hFFFF_FFFF_FFFF_FFFC, 1);
      step();
      check("w_head", fq_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      check("w_wrap_pc", imem_addr, 64'h0);
      step();
      fq_ready = 1'b0;
      check("w_drain", 64'(exp_q.size()), 64'd0);
      repeat (3) step();
      check("d_full", 64'(fq_count), 64'd4);

      // Reset mid-stream with the queue full
      reset = 1'b0;
      #1;
      check("d_valid", 64'(fq_valid), 64'd0);
      check("d_count", 64'(fq_count), 64'd0);
      check("d_addr", imem_addr, 64'h0);
      check("d_pc_zero", fq_pc, 64'h0);
      repeat (3) @(posedge clk);
      @(negedge clk) begin reset = 1'b1; fq_ready = 1'b1; end
      expect_seq(64'h0, 2);
      for (int i = 0; i < 3; i++) begin
         step();
         check("d_head", fq_pc, 64'(4 * i));
         check("d_count_one", 64'(fq_count), 64'd1);
      end
      fq_ready = 1'b0;
      check("d_drain", 64'(exp_q.size()), 64'd0);

`ifdef FETCH_STATIC_PREDICT_EN
      redir_kind = 2'b10; redir_reg_pc = 64'h2000; fq_ready = 1'b1;
      step();
      redir_kind = 2'b00;
      exp_q.push_back(64'h2000);
      exp_q.push_back(64'h2010);
      step();
      check("p_b_next", imem_addr, 64'h2010);
      check("p_b_pred", 64'(fq_pred_taken), 64'd1);
      step();
      check("p_cbz_fwd_next", imem_addr, 64'h2014);
      check("p_cbz_fwd_pred", 64'(fq_pred_taken), 64'd0);
      step();
      fq_ready = 1'b0;
      check("p_cbz_bwd_next", imem_addr, 64'h2008);
      check("p_cbz_bwd_pred", 64'(fq_pred_taken), 64'd1);
      check("p_drain", 64'(exp_q.size()), 64'd0);
`endif

      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
